prefetch_buffer: RTL

PREFETCH_BUFFER -- requirements
Module: prefetch_buffer

---
 rtl/prefetch_buffer_pkg.sv | 38 +++
 rtl/prefetch_decode.sv | 43 ++++
 rtl/prefetch_buffer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/prefetch_buffer_pkg.sv
// prefetch_buffer_pkg: Y86 icodes, stat codes, FSM states and instruction-length helpers
package prefetch_buffer_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SHLT = 3'd2;
   localparam logic [2:0] SADR = 3'd3;
   localparam logic [2:0] SINS = 3'd4;

   typedef enum logic {RUN, STOP} state_e;

   function automatic logic need_regids(input logic [3:0] icode);
      return icode inside {IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ};
   endfunction

   function automatic logic need_valc(input logic [3:0] icode);
      return icode inside {IIRMOVQ, IRMMOVQ, IMRMOVQ, IJXX, ICALL};
   endfunction

   // Invalid icodes occupy a single byte so the fetch stage can report them
   function automatic logic [3:0] instr_len(input logic [3:0] icode);
      return (icode >= 4'hC) ? 4'd1
           : 4'd1 + {3'd0, need_regids(icode)} + (need_valc(icode) ? 4'd8 : 4'd0);
   endfunction

endpackage

// File: rtl/prefetch_decode.sv
// prefetch_decode: combinational Y86 decode of the 10-byte window at the queue head
module prefetch_decode
   import prefetch_buffer_pkg::*;
(
   input  logic        en_i,
   input  logic [79:0] win_i,
   input  logic [9:0]  err_i,
   input  logic [3:0]  avail_i,
   output logic        valid_o,
   output logic [3:0]  icode_o,
   output logic [3:0]  ifun_o,
   output logic [3:0]  rA_o,
   output logic [3:0]  rB_o,
   output logic [63:0] valC_o,
   output logic [3:0]  len_o,
   output logic [2:0]  stat_o
);

   logic [3:0] icode;
   logic       regids;
   logic       adr;

   // Decode head; fields are zero when not valid and independent of bytes past the
   // instruction (or past an error) so they hold still while the consumer stalls
   always_comb begin
      icode  = win_i[7:4];
      len_o  = instr_len(icode);
      regids = need_regids(icode);
      adr    = 1'b0;
      for (int k = 0; k < 10; k++)
         adr = adr | (err_i[k] & (4'(k) < len_o) & (4'(k) < avail_i));
      valid_o = en_i & (avail_i != 4'd0) & ((avail_i >= len_o) | adr);
      icode_o = valid_o ? icode : 4'd0;
      ifun_o  = valid_o ? win_i[3:0] : 4'd0;
      rA_o    = ~valid_o ? 4'd0 : (regids & ~adr) ? win_i[15:12] : 4'hF;
      rB_o    = ~valid_o ? 4'd0 : (regids & ~adr) ? win_i[11:8] : 4'hF;
      valC_o  = (~valid_o | adr | ~need_valc(icode)) ? 64'd0
              : regids ? win_i[79:16] : win_i[71:8];
      stat_o  = ~valid_o ? 3'd0 : adr ? SADR : (icode >= 4'hC) ? SINS
              : (icode == IHALT) ? SHLT : SAOK;
   end

endmodule

// File: rtl/prefetch_buffer.sv
// prefetch_buffer: Y86 byte-queue prefetcher with head decode; PF_PERF_CNT_EN adds stall_cnt_o
module prefetch_buffer
   import prefetch_buffer_pkg::*;
#(
   parameter int FETCH_BYTES = 8,
   parameter int QUEUE_BYTES = 32,
   parameter int MAX_OUTST   = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     redirect_i,
   input  logic [63:0]              redirect_pc_i,
   output logic                     mem_req_o,
   output logic [63:0]              mem_addr_o,
   input  logic                     mem_gnt_i,
   input  logic                     mem_rvalid_i,
   input  logic [FETCH_BYTES*8-1:0] mem_rdata_i,
   input  logic                     mem_err_i,
   output logic                     f_valid_o,
   input  logic                     f_ready_i,
   output logic [63:0]              f_pc_o,
   output logic [3:0]               f_icode_o,
   output logic [3:0]               f_ifun_o,
   output logic [3:0]               f_rA_o,
   output logic [3:0]               f_rB_o,
   output logic [63:0]              f_valC_o,
   output logic [63:0]              f_valP_o,
   output logic [2:0]               f_stat_o
`ifdef PF_PERF_CNT_EN
   ,
   output logic [31:0]              stall_cnt_o
`endif
);

   localparam int AW = $clog2(QUEUE_BYTES);
   localparam int CW = AW + 1;
   localparam int FW = $clog2(FETCH_BYTES);

   state_e                 state_q, state_d;
   logic [63:0]            pc_q, pc_d, addr_q, addr_d;
   logic [AW-1:0]          rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]          cnt_q, cnt_d, push_n;
   logic [2:0]             outst_q, outst_d, stale_q, stale_d;
   logic [FW-1:0]          drop_q, drop_d;
   logic [7:0]             qd_q [QUEUE_BYTES];
   logic [QUEUE_BYTES-1:0] qe_q;
   logic [79:0]            win;
   logic [9:0]             win_err;
   logic [3:0]             avail, len;
   logic [FETCH_BYTES*8-1:0] rsp_sh;
   logic                   gnt, stale_rsp, live_rsp, push, xfer;

   // Gather the ten head bytes and their error flags for the decoder
   always_comb begin
      for (int k = 0; k < 10; k++) begin
         win[k*8 +: 8] = qd_q[rd_q + AW'(k)];
         win_err[k]    = qe_q[rd_q + AW'(k)];
      end
      avail = (cnt_q > CW'(10)) ? 4'd10 : cnt_q[3:0];
   end

   prefetch_decode u_dec (
      .en_i    (state_q == RUN),
      .win_i   (win),
      .err_i   (win_err),
      .avail_i (avail),
      .valid_o (f_valid_o),
      .icode_o (f_icode_o),
      .ifun_o  (f_ifun_o),
      .rA_o    (f_rA_o),
      .rB_o    (f_rB_o),
      .valC_o  (f_valC_o),
      .len_o   (len),
      .stat_o  (f_stat_o)
   );

   // Room is reserved for every live response still in flight; stale ones are dropped
   assign mem_req_o  = rst_n_i & (state_q == RUN)
                     & (int'(outst_q) + int'(stale_q) < MAX_OUTST)
                     & (QUEUE_BYTES - int'(cnt_q) >= FETCH_BYTES * (int'(outst_q) + 1));
   assign mem_addr_o = addr_q;
   assign f_pc_o     = pc_q;
   assign f_valP_o   = f_valid_o ? pc_q + 64'(len) : 64'd0;
   assign gnt        = mem_gnt_i & mem_req_o;
   assign stale_rsp  = mem_rvalid_i & (stale_q != 3'd0);
   assign live_rsp   = mem_rvalid_i & (stale_q == 3'd0) & (outst_q != 3'd0);
   assign push       = live_rsp & (state_q == RUN);
   assign push_n     = CW'(FETCH_BYTES) - CW'(drop_q);
   assign rsp_sh     = mem_rdata_i >> {drop_q, 3'b000};
   assign xfer       = f_valid_o & f_ready_i;

   // Next state: redirect overrides everything; a faulting transfer flushes and stops
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      outst_d = outst_q;
      stale_d = stale_q;
      drop_d  = drop_q;
      if (redirect_i) begin
         state_d = RUN;
         pc_d    = redirect_pc_i;
         addr_d  = {redirect_pc_i[63:FW], FW'(0)};
         rd_d    = '0;
         wr_d    = '0;
         cnt_d   = '0;
         outst_d = '0;
         stale_d = stale_q + outst_q + 3'(gnt) - 3'(stale_rsp | live_rsp);
         drop_d  = redirect_pc_i[FW-1:0];
      end else begin
         if (gnt) addr_d = addr_q + 64'(FETCH_BYTES);
         outst_d = outst_q + 3'(gnt) - 3'(live_rsp);
         stale_d = stale_q - 3'(stale_rsp);
         if (live_rsp) drop_d = '0;
         if (xfer) pc_d = f_valP_o;
         if (xfer && f_stat_o != SAOK) begin
            state_d = STOP;
            rd_d    = wr_q;
            cnt_d   = '0;
         end else begin
            if (push) wr_d = wr_q + AW'(push_n);
            if (xfer) rd_d = rd_q + AW'(len);
            cnt_d = cnt_q + (push ? push_n : '0) - (xfer ? CW'(len) : '0);
         end
      end
   end

   // Control registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= RUN;
         pc_q    <= '0;
         addr_q  <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
         outst_q <= '0;
         stale_q <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         outst_q <= outst_d;
         stale_q <= stale_d;
         drop_q  <= drop_d;
      end
   end

   // Queue storage: write the kept bytes of a live response, all tagged with its error bit
   always_ff @(posedge clk_i) begin
      if (push) begin
         for (int j = 0; j < FETCH_BYTES; j++) begin
            if (CW'(j) < push_n) begin
               qd_q[wr_q + AW'(j)] <= rsp_sh[j*8 +: 8];
               qe_q[wr_q + AW'(j)] <= mem_err_i;
            end
         end
      end
   end

`ifdef PF_PERF_CNT_EN
   logic [31:0] stall_q;

   // Saturating count of RUN cycles with nothing to hand to the consumer
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) stall_q <= '0;
      else if (state_q == RUN && !f_valid_o && stall_q != '1) stall_q <= stall_q + 32'd1;
   end

   assign stall_cnt_o = stall_q;
`endif

endmodule
